// File: rtl/key_debouncer_pkg.sv
// Shared types and constants for the pushbutton debouncer.
// The FSM state type is reused by anything that wants to observe debouncer state.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    REL_STABLE,
    PRESS_WAIT,
    PRS_STABLE,
    REL_WAIT
  } deb_state_t;

  // 50 MHz board clock x 1 ms of required stability.
  localparam int DEF_STABLE_CYCLES = 50000;

endpackage

// File: rtl/key_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Resets to RST_VAL so the downstream logic sees a known idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces one raw pushbutton into a clean level plus press/release pulses.
// Define KEY_DEBOUNCER_TOGGLE_EN to add the push-on/push-off key_toggle output.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
`ifdef KEY_DEBOUNCER_TOGGLE_EN
  ,
  output logic key_toggle
`endif
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic             REL_VAL  = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_sync;
  logic             s;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_2ff #(.RST_VAL(REL_VAL)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (key_in),
    .q_o   (key_sync)
  );

  assign s = ACTIVE_LOW ? ~key_sync : key_sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      REL_STABLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = REL_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS_STABLE: begin
        if (!s) begin
          state_d = REL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      REL_WAIT: begin
        if (s) begin
          state_d = PRS_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered one stage behind the committed state; pulses mark level edges.
  always_comb begin
    level_d   = (state_q == PRS_STABLE) || (state_q == REL_WAIT);
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REL_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_DEBOUNCER_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge clk) begin
    if (rst) toggle_q <= 1'b0;
    else     toggle_q <= toggle_q ^ press_d;
  end

  assign key_toggle = toggle_q;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with STABLE_CYCLES=4, ACTIVE_LOW=1.
// Expected press/release events are queued with their due cycle and matched by a monitor.
module tb_key_debouncer;

  localparam int SC  = 4;
  localparam int LAT = SC + 2;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
`ifdef KEY_DEBOUNCER_TOGGLE_EN
  logic key_toggle;
  logic exp_toggle = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [17:0] exp_q[$];

  key_debouncer #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_DEBOUNCER_TOGGLE_EN
    ,
    .key_toggle  (key_toggle)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // key_in was just changed; the edge after now is E0, the event is due at E0+LAT.
  task automatic push_evt(input bit is_press);
    logic [15:0] due;
    due = 16'(cyc + 1 + LAT);
    exp_q.push_back({due, is_press ? 2'b10 : 2'b01});
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [17:0] e;
    #1;
    if (exp_q.size() > 0 && int'(exp_q[0][17:2]) < cyc) begin
      e = exp_q.pop_front();
      check_eq("missed_evt", 32'(cyc), 32'(e[17:2]));
    end
    if (key_press === 1'b1 && key_release === 1'b1)
      check_eq("excl_pulses", 32'd1, 32'd0);
    if (key_press === 1'b1 || key_release === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_pulse", 32'({key_press, key_release}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("evt_cycle", 32'(cyc), 32'(e[17:2]));
        check_eq("evt_kind", 32'({key_press, key_release}), 32'(e[1:0]));
        check_eq("evt_level", 32'(key_level), 32'(e[1]));
`ifdef KEY_DEBOUNCER_TOGGLE_EN
        if (key_press === 1'b1) begin
          exp_toggle = ~exp_toggle;
          check_eq("toggle", 32'(key_toggle), 32'(exp_toggle));
        end
`endif
      end
    end
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_level"}, 32'(key_level), 32'd0);
    check_eq({tag, "_press"}, 32'(key_press), 32'd0);
    check_eq({tag, "_release"}, 32'(key_release), 32'd0);
`ifdef KEY_DEBOUNCER_TOGGLE_EN
    check_eq({tag, "_toggle"}, 32'(key_toggle), 32'd0);
`endif
  endtask

  initial begin
    int g;
    // reset with the key held pressed
    rst    = 1'b1;
    key_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_idle("in_rst");
    end
    rst = 1'b0;
    push_evt(1'b1);
    step(1);
    check_idle("post_rst");
    step(LAT + 2);
    check_eq("held_press_level", 32'(key_level), 32'd1);

    // clean release, then clean press
    key_in = 1'b1;
    push_evt(1'b0);
    step(LAT + 3);
    check_eq("rel_level", 32'(key_level), 32'd0);
    key_in = 1'b0;
    push_evt(1'b1);
    step(LAT + 3);
    check_eq("press_level", 32'(key_level), 32'd1);

    // short release glitches from the pressed state are ignored
    key_in = 1'b1;
    step(3);
    key_in = 1'b0;
    step(LAT + 2);
    check_eq("glitch3_level", 32'(key_level), 32'd1);
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(1, SC - 1);
      key_in = 1'b1;
      step(g);
      key_in = 1'b0;
      step(LAT + 2);
      check_eq("glitch_rand_level", 32'(key_level), 32'd1);
    end

    // clean release
    key_in = 1'b1;
    push_evt(1'b0);
    step(LAT + 3);
    check_eq("rel2_level", 32'(key_level), 32'd0);

    // bounce: toggle every 2 cycles for 20 cycles, then hold pressed
    for (int i = 0; i < 10; i++) begin
      key_in = i[0];
      step(2);
      check_eq("bounce_level", 32'(key_level), 32'd0);
    end
    key_in = 1'b0;
    push_evt(1'b1);
    step(LAT + 3);
    check_eq("bounce_press_level", 32'(key_level), 32'd1);

    // release, then reset in the middle of a press wait (counter=2)
    key_in = 1'b1;
    push_evt(1'b0);
    step(LAT + 3);
    key_in = 1'b0;
    step(4);
    rst = 1'b1;
`ifdef KEY_DEBOUNCER_TOGGLE_EN
    exp_toggle = 1'b0;
`endif
    step(1);
    check_idle("mid_wait_rst");
    rst = 1'b0;
    push_evt(1'b1);
    step(LAT);
    check_eq("rst_repress_early", 32'(key_level), 32'd0);
    step(2);
    check_eq("rst_repress_level", 32'(key_level), 32'd1);

    // three release/press cycles; toggle follows each press
    for (int i = 0; i < 3; i++) begin
      key_in = 1'b1;
      push_evt(1'b0);
      step(LAT + 2);
      key_in = 1'b0;
      push_evt(1'b1);
      step(LAT + 2);
      check_eq("cycle_level", 32'(key_level), 32'd1);
    end

    step(LAT + 2);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
